// File: rtl/axis_gen_mc_if.sv
// AXI-Stream style interface: data/vld/last driven by the source, rdy by the sink.
interface axis_if #(
    parameter int DATAW = 64
);
    logic [DATAW-1:0] data;
    logic             vld;
    logic             last;
    logic             rdy;

    modport out  (output data, vld, last, input rdy);
    modport sink (input data, vld, last, output rdy);
endinterface

// File: rtl/axis_gen_mc.sv
// Stream packet generator: LFSR / count / all-ones payload, configurable length, count and gap.
// Define AXIS_GEN_MC_HDR_EN to make the first beat of each packet a {pkt_cnt, len} header.
module axis_gen_mc #(
    parameter int          DATAW   = 64,
    parameter int          MAX_LEN = 256,
    parameter logic [63:0] SEED    = 64'hFEDCBA9876543210
) (
    input  logic                         clk,
    input  logic                         s_rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic [1:0]                   mode,
    input  logic [$clog2(MAX_LEN+1)-1:0] pkt_len,
    input  logic [15:0]                  num_pkts,
    input  logic [7:0]                   gap,
    axis_if.out                          m_axis,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  pkt_cnt
);
    localparam int LW = $clog2(MAX_LEN+1);
    localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t           state, state_nxt;
    logic [1:0]       mode_q;
    logic [LW-1:0]    len_q, beat_idx, len_in;
    logic [15:0]      num_q, pkt_cnt_q;
    logic [7:0]       gap_q, gap_cnt;
    logic [63:0]      lfsr, lfsr_nxt;
    logic [DATAW-1:0] run_cnt, payload;
    logic             stop_pend, done_q;
    logic             start_ok, xfer, last_beat, hdr_beat, pay_step, run_end;

    always_comb begin
        start_ok  = start && !stop;
        xfer      = (state == SEND) && m_axis.rdy;
        last_beat = (beat_idx == len_q - LW'(1));
`ifdef AXIS_GEN_MC_HDR_EN
        hdr_beat  = (beat_idx == '0);
`else
        hdr_beat  = 1'b0;
`endif
        pay_step  = xfer && !hdr_beat;
        // A stop arriving on the last beat itself still ends the run there
        run_end   = stop || stop_pend || ((num_q != 16'd0) && (pkt_cnt_q + 16'd1 == num_q));
        lfsr_nxt  = {1'b0, lfsr[63:1]} ^ ({64{lfsr[0]}} & LFSR_MASK);
        if (pkt_len == '0)
            len_in = LW'(1);
        else if (pkt_len > LW'(MAX_LEN))
            len_in = LW'(MAX_LEN);
        else
            len_in = pkt_len;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = SEND;
            SEND: begin
                if (xfer && last_beat) begin
                    if (run_end)            state_nxt = IDLE;
                    else if (gap_q == 8'd0) state_nxt = SEND;
                    else                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (stop)                 state_nxt = IDLE;
                else if (gap_cnt == 8'd1) state_nxt = SEND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            mode_q    <= 2'd0;
            len_q     <= LW'(1);
            num_q     <= 16'd0;
            gap_q     <= 8'd0;
            gap_cnt   <= 8'd0;
            lfsr      <= SEED;
            run_cnt   <= '0;
            beat_idx  <= '0;
            pkt_cnt_q <= 16'd0;
            stop_pend <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state != IDLE) && (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        mode_q    <= mode;
                        len_q     <= len_in;
                        num_q     <= num_pkts;
                        gap_q     <= gap;
                        lfsr      <= SEED;
                        run_cnt   <= '0;
                        beat_idx  <= '0;
                        pkt_cnt_q <= 16'd0;
                        stop_pend <= 1'b0;
                    end
                end
                SEND: begin
                    if (stop) stop_pend <= 1'b1;
                    if (pay_step) begin
                        lfsr    <= lfsr_nxt;
                        run_cnt <= run_cnt + DATAW'(1);
                    end
                    if (xfer) begin
                        if (last_beat) begin
                            beat_idx <= '0;
                            gap_cnt  <= gap_q;
                            if (pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
                        end else begin
                            beat_idx <= beat_idx + LW'(1);
                        end
                    end
                end
                GAP: gap_cnt <= gap_cnt - 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (mode_q)
            2'd1:    payload = run_cnt;
            2'd2:    payload = '1;
            default: payload = lfsr[DATAW-1:0];
        endcase
    end

`ifdef AXIS_GEN_MC_HDR_EN
    logic [15+LW:0] hdr;
    assign hdr         = {pkt_cnt_q, len_q};
    assign m_axis.data = (state == SEND && hdr_beat) ? DATAW'(hdr) : payload;
`else
    assign m_axis.data = payload;
`endif
    assign m_axis.vld  = (state == SEND);
    assign m_axis.last = (state == SEND) && last_beat;
    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign pkt_cnt     = pkt_cnt_q;
endmodule

// File: tb/tb_axis_gen_mc.sv
// Directed bench for axis_gen_mc (DATAW=64, MAX_LEN=8, header disabled).
module tb_axis_gen_mc;
    localparam logic [63:0] SEED = 64'hFEDCBA9876543210;

    logic        clk = 1'b0, s_rst_n = 1'b0, start = 1'b0, stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  pkt_len = 4'd0;
    logic [15:0] num_pkts = 16'd0;
    logic [7:0]  gap = 8'd0;
    logic        busy, done;
    logic [15:0] pkt_cnt;
    int          checks = 0, failures = 0;

    axis_if #(.DATAW(64)) ax ();

    axis_gen_mc #(.DATAW(64), .MAX_LEN(8), .SEED(SEED)) dut (
        .clk(clk), .s_rst_n(s_rst_n), .start(start), .stop(stop), .mode(mode),
        .pkt_len(pkt_len), .num_pkts(num_pkts), .gap(gap), .m_axis(ax),
        .busy(busy), .done(done), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Galois form of x^64+x^63+x^61+x^60+1, shifting right
    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        logic [63:0] n;
        n = s >> 1;
        if (s[0]) begin
            n[63] = ~n[63];
            n[62] = ~n[62];
            n[60] = ~n[60];
            n[59] = ~n[59];
        end
        return n;
    endfunction

    task automatic go(input logic [1:0] m, input logic [3:0] l, input logic [15:0] n, input logic [7:0] g);
        mode = m; pkt_len = l; num_pkts = n; gap = g;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_d;
        int          beat;
        int          pat [8];
        ax.rdy = 1'b1;
        pat = '{1, 1, 1, 0, 0, 1, 1, 1};

        step(); step();
        chk("rst vld", ax.vld, 1'b0);
        chk("rst last", ax.last, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst pkt_cnt", pkt_cnt, 16'd0);
        chk("rst data", ax.data, SEED);
        s_rst_n = 1'b1;
        step();

        // count mode, two back-to-back 4-beat packets
        go(2'd1, 4'd4, 16'd2, 8'd0);
        chk("cnt busy", busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("cnt vld", ax.vld, 1'b1);
            chk("cnt data", ax.data, 64'(i));
            chk("cnt last", ax.last, (i % 4) == 3);
            step();
        end
        chk("cnt done", done, 1'b1);
        chk("cnt busy end", busy, 1'b0);
        chk("cnt vld end", ax.vld, 1'b0);
        chk("cnt pkt_cnt", pkt_cnt, 16'd2);
        step();
        chk("cnt done 1cyc", done, 1'b0);
        chk("cnt pkt_cnt hold", pkt_cnt, 16'd2);

        // LFSR mode with a 5-cycle stall after beat 2
        go(2'd0, 4'd8, 16'd1, 8'd0);
        exp_d = SEED;
        beat  = 0;
        for (int c = 0; c < 13; c++) begin
            ax.rdy = !(c >= 3 && c <= 7);
            chk("lfsr vld", ax.vld, 1'b1);
            chk("lfsr data", ax.data, exp_d);
            chk("lfsr last", ax.last, beat == 7);
            step();
            if (ax.rdy) begin
                exp_d = lfsr_next(exp_d);
                beat++;
            end
        end
        ax.rdy = 1'b1;
        chk("lfsr done", done, 1'b1);
        chk("lfsr pkt_cnt", pkt_cnt, 16'd1);

        // constant mode, gap of 2 between two 3-beat packets
        go(2'd2, 4'd3, 16'd2, 8'd2);
        for (int c = 0; c < 8; c++) begin
            chk("gap vld", ax.vld, pat[c][0]);
            chk("gap busy", busy, 1'b1);
            chk("gap last", ax.last, c == 2 || c == 7);
            if (pat[c] == 1) chk("gap data", ax.data, 64'hFFFF_FFFF_FFFF_FFFF);
            step();
        end
        chk("gap done", done, 1'b1);
        chk("gap pkt_cnt", pkt_cnt, 16'd2);

        // unbounded run, stop during beat 1 finishes the packet
        go(2'd1, 4'd8, 16'd0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            stop = (i == 1);
            chk("stop data", ax.data, 64'(i));
            chk("stop last", ax.last, i == 7);
            step();
        end
        stop = 1'b0;
        chk("stop done", done, 1'b1);
        chk("stop busy", busy, 1'b0);
        chk("stop vld", ax.vld, 1'b0);
        chk("stop pkt_cnt", pkt_cnt, 16'd1);

        // pkt_len=0 means single-beat packets; start while busy ignored
        go(2'd1, 4'd0, 16'd3, 8'd0);
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            if (i == 1) num_pkts = 16'd0;
            chk("len0 vld", ax.vld, 1'b1);
            chk("len0 data", ax.data, 64'(i));
            chk("len0 last", ax.last, 1'b1);
            step();
        end
        start = 1'b0;
        chk("len0 done", done, 1'b1);
        chk("len0 pkt_cnt", pkt_cnt, 16'd3);

        // pkt_len above MAX_LEN clamps to 8 beats
        go(2'd1, 4'd12, 16'd1, 8'd0);
        for (int i = 0; i < 8; i++) begin
            chk("clamp last", ax.last, i == 7);
            step();
        end
        chk("clamp done", done, 1'b1);

        // stop while in GAP
        go(2'd2, 4'd1, 16'd0, 8'd5);
        chk("sgap last", ax.last, 1'b1);
        step();
        chk("sgap vld", ax.vld, 1'b0);
        chk("sgap busy", busy, 1'b1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("sgap done", done, 1'b1);
        chk("sgap busy end", busy, 1'b0);
        chk("sgap pkt_cnt", pkt_cnt, 16'd1);

        // start together with stop in IDLE is ignored
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("ss busy", busy, 1'b0);
        step();
        chk("ss vld", ax.vld, 1'b0);
        chk("ss pkt_cnt hold", pkt_cnt, 16'd1);

        // asynchronous reset mid-packet
        go(2'd0, 4'd8, 16'd1, 8'd0);
        step(); step();
        chk("arst pre data", ax.data, lfsr_next(lfsr_next(SEED)));
        #1 s_rst_n = 1'b0;
        #1;
        chk("arst vld", ax.vld, 1'b0);
        chk("arst busy", busy, 1'b0);
        chk("arst pkt_cnt", pkt_cnt, 16'd0);
        chk("arst data", ax.data, SEED);
        step();
        s_rst_n = 1'b1;
        step();
        chk("arst no beat", ax.vld, 1'b0);
        go(2'd0, 4'd8, 16'd1, 8'd0);
        chk("arst restart vld", ax.vld, 1'b1);
        chk("arst restart data", ax.data, SEED);
        step();
        chk("arst restart next", ax.data, lfsr_next(SEED));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_gen_mc.md
AXIS_GEN_MC -- requirements
Module: axis_gen_mc

Interface
REQ-001 SHALL have parameter DATAW, default 64, payload width in bits, legal range 1..64.
REQ-002 SHALL have parameter MAX_LEN, default 256, maximum beats per packet, at least 1.
REQ-003 SHALL have parameter SEED, default 64'hFEDCBA9876543210, LFSR reload value, nonzero.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port s_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit, single-cycle pulse that starts a run.
REQ-007 SHALL have port stop, input, 1 bit, single-cycle pulse that ends a run early.
REQ-008 SHALL have port mode, input, 2 bits: 0=LFSR, 1=incrementing count, 2=constant all-ones, 3=reserved (treated as 0).
REQ-009 SHALL have port pkt_len, input, $clog2(MAX_LEN+1) bits, beats per packet.
REQ-010 SHALL have port num_pkts, input, 16 bits, packets per run; 0 means run until stop.
REQ-011 SHALL have port gap, input, 8 bits, idle cycles between packets.
REQ-012 SHALL have port m_axis, axis_if.out, DATAW, output stream carrying data, vld and last out and rdy in.
REQ-013 SHALL have port busy, output, 1 bit, high while a run is active.
REQ-014 SHALL have port done, output, 1 bit, one-cycle pulse when a run ends.
REQ-015 SHALL have port pkt_cnt, output, 16 bits, packets fully sent in the current or last run.

Function
REQ-016 SHALL implement an FSM with states IDLE, SEND and GAP.
REQ-017 In IDLE, start with stop low SHALL latch mode, pkt_len, num_pkts and gap, reload the LFSR with SEED, clear the beat counter and pkt_cnt, and enter SEND; m_axis.vld SHALL be high on the next cycle.
REQ-018 A beat SHALL transfer only when vld and rdy are both high; while vld is high and rdy is low, data and last SHALL hold stable.
REQ-019 vld SHALL stay high in SEND regardless of rdy; vld SHALL be low in IDLE and GAP.
REQ-020 Latched pkt_len of 0 SHALL be treated as 1; values above MAX_LEN SHALL be clamped to MAX_LEN.
REQ-021 last SHALL be high on the final beat of each packet only.
REQ-022 LFSR mode: data SHALL be lfsr[DATAW-1:0], from a 64-bit Galois LFSR with taps 64,63,61,60 that steps once per transfer only.
REQ-023 Count mode: data SHALL be the run beat index (0,1,2,...) zero-extended or truncated to DATAW, wrapping modulo 2^DATAW, and SHALL advance per transfer.
REQ-024 Constant mode: data SHALL be all ones.
REQ-025 On the last-beat transfer, pkt_cnt SHALL increment.
REQ-026 On the last-beat transfer, if the run is complete, the FSM SHALL go to IDLE; otherwise it SHALL go to SEND if gap=0 (back-to-back) or to GAP if gap>0.
REQ-027 GAP SHALL last exactly gap cycles, then enter SEND.
REQ-028 pkt_cnt SHALL saturate at 16'hFFFF when num_pkts=0.
REQ-029 stop in SEND SHALL finish the current packet, then go to IDLE.
REQ-030 stop in GAP SHALL go to IDLE on the next cycle.
REQ-031 stop in IDLE SHALL have no effect; start with stop in the same cycle in IDLE SHALL be ignored.
REQ-032 start SHALL be ignored while busy.
REQ-033 On entering IDLE from SEND or GAP, done SHALL pulse for one cycle and busy SHALL fall in that same cycle.
REQ-034 pkt_cnt SHALL hold its value in IDLE until the next start.

Reset
REQ-035 Asserting s_rst_n low SHALL force, immediately: state IDLE, vld=0, last=0, busy=0, done=0, pkt_cnt=0, LFSR=SEED, beat counter=0.
REQ-036 data SHALL reset to SEED[DATAW-1:0].
REQ-037 Reset mid-packet SHALL abort with no further beats; a new start is required afterward.

Configuration
REQ-038 With AXIS_GEN_MC_HDR_EN defined, the first beat of each packet SHALL carry a header, {pkt_cnt[15:0], latched pkt_len} zero-extended or truncated to DATAW, and that beat SHALL NOT step the payload generator.
REQ-039 Without AXIS_GEN_MC_HDR_EN, all beats SHALL be payload.

Verification
REQ-040 mode=1, pkt_len=4, num_pkts=2, gap=0, rdy=1 -> data 0..7, last on beats 3 and 7, done one cycle after beat 7, pkt_cnt=2.
REQ-041 mode=0, DATAW=64, rdy low for 5 cycles mid-packet -> data and last stable while stalled; the sequence equals the golden LFSR from SEED with no skipped values.
REQ-042 pkt_len=3, gap=2, num_pkts=2 -> exactly 2 vld-low cycles between the two packets.
REQ-043 num_pkts=0, stop during beat 1 of a pkt_len=8 packet -> packet completes through beat 7 with last, then done, busy=0.
REQ-044 s_rst_n low mid-packet -> vld=0 immediately; start afterward restarts the LFSR from SEED.
REQ-045 pkt_len=0 -> single-beat packets with last on every beat; with AXIS_GEN_MC_HDR_EN, the first beat equals {pkt_cnt, len}.
